// File: rtl/collision_scorer_if.sv
// Pixel-domain bundle between the object managers, the collision scorer and vga_sync.
// The master side drives the pixel flags, frame tick and new-game request.
interface collision_scorer_if #(
  parameter int N_OBJ   = 15,
  parameter int SCORE_W = 16
);
  logic [N_OBJ-1:0]   iPixels;
  logic               iFrameTick;
  logic               iNewGame;
  logic [N_OBJ-1:0]   oReset;
  logic               oPixel;
  logic [SCORE_W-1:0] oScore;
  logic [SCORE_W-1:0] oHighScore;
  logic [2:0]         oLives;
  logic [1:0]         oState;
  logic               oGameOver;

  modport master (
    output iPixels, iFrameTick, iNewGame,
    input  oReset, oPixel, oScore, oHighScore, oLives, oState, oGameOver
  );

  modport slave (
    input  iPixels, iFrameTick, iNewGame,
    output oReset, oPixel, oScore, oHighScore, oLives, oState, oGameOver
  );
endinterface

// File: rtl/collision_scorer.sv
// Per-frame collision accumulation with frame-tick commit of score, lives and game state.
// Define COLLISION_SCORER_HIGH_SCORE_EN to keep a high-score register; otherwise oHighScore is 0.
//
// state  | meaning
// IDLE   | no game running, commits ignored
// PLAY   | normal play, ship hits cost a life
// INVULN | ship hits ignored for INVULN_FRAMES commits, ship blinks
// OVER   | lives exhausted, waiting for iNewGame
module collision_scorer #(
  parameter int N_BULLET      = 4,
  parameter int N_ROCK        = 10,
  parameter int SCORE_W       = 16,
  parameter int POINTS        = 10,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 120
) (
  input logic               iCLK,
  input logic               iRST_N,
  collision_scorer_if.slave bus
);
  localparam int N_OBJ = 1 + N_BULLET + N_ROCK;
  localparam int PW    = $clog2(N_ROCK + 1);
  localparam int WW    = SCORE_W + 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_INVULN = 2'd2, S_OVER = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [N_BULLET-1:0] bhit_q, bhit_d, bhit_now;
  logic [N_ROCK-1:0]   rhit_q, rhit_d, rhit_now;
  logic                shit_q, shit_d, shit_now;
  logic [SCORE_W-1:0]  score_q, score_d, score_sat;
  logic [2:0]          lives_q, lives_d;
  logic [7:0]          inv_q, inv_d, frame_q, frame_d;
  logic [N_OBJ-1:0]    rst_q, rst_d;
  logic [PW-1:0]       pop;
  logic [WW-1:0]       sum;
  logic [N_BULLET-1:0] bullets;
  logic [N_ROCK-1:0]   rocks;
  logic                any_bullet, any_rock;

  assign bullets    = bus.iPixels[N_BULLET:1];
  assign rocks      = bus.iPixels[N_OBJ-1:N_BULLET+1];
  assign any_bullet = |bullets;
  assign any_rock   = |rocks;
  assign bhit_now   = any_rock ? bullets : '0;
  assign rhit_now   = any_bullet ? rocks : '0;
  assign shit_now   = bus.iPixels[0] & any_rock;

  // The tick cycle's own hits start the new frame rather than joining the committed one
  assign bhit_d = bus.iFrameTick ? bhit_now : (bhit_q | bhit_now);
  assign rhit_d = bus.iFrameTick ? rhit_now : (rhit_q | rhit_now);
  assign shit_d = bus.iFrameTick ? shit_now : (shit_q | shit_now);

  always_comb begin
    pop = '0;
    for (int j = 0; j < N_ROCK; j++) pop = pop + PW'(rhit_q[j]);
  end

  assign sum       = WW'(score_q) + WW'(pop) * WW'(POINTS);
  assign score_sat = (|sum[WW-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      bhit_q  <= '0;
      rhit_q  <= '0;
      shit_q  <= 1'b0;
      score_q <= '0;
      lives_q <= '0;
      inv_q   <= '0;
      frame_q <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      bhit_q  <= bhit_d;
      rhit_q  <= rhit_d;
      shit_q  <= shit_d;
      score_q <= score_d;
      lives_q <= lives_d;
      inv_q   <= inv_d;
      frame_q <= frame_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    inv_d   = inv_q;
    frame_d = frame_q;
    rst_d   = '0;
    if (bus.iFrameTick) begin
      frame_d = frame_q + 8'd1;
      if (bus.iNewGame) begin
        rst_d   = '1;
        score_d = '0;
        lives_d = 3'(LIVES_INIT);
        state_d = S_PLAY;
      end else if (state_q == S_PLAY || state_q == S_INVULN) begin
        rst_d   = {rhit_q, bhit_q, 1'b0};
        score_d = score_sat;
        if (state_q == S_PLAY && shit_q) begin
          lives_d = lives_q - 3'd1;
          if (lives_d == 3'd0) begin
            state_d = S_OVER;
          end else begin
            rst_d[0] = 1'b1;
            state_d  = S_INVULN;
            inv_d    = 8'(INVULN_FRAMES);
          end
        end else if (state_q == S_INVULN) begin
          inv_d = inv_q - 8'd1;
          if (inv_d == 8'd0) state_d = S_PLAY;
        end
      end
    end
  end

  always_comb begin
    bus.oState    = state_q;
    bus.oGameOver = (state_q == S_OVER);
    bus.oPixel    = (|bus.iPixels[N_OBJ-1:1]) |
                    (bus.iPixels[0] & ~(state_q == S_INVULN && frame_q[3]));
  end

  assign bus.oScore = score_q;
  assign bus.oLives = lives_q;
  assign bus.oReset = rst_q;

`ifdef COLLISION_SCORER_HIGH_SCORE_EN
  logic [SCORE_W-1:0] hi_q, hi_d;

  always_comb begin
    hi_d = hi_q;
    if (state_d == S_OVER && state_q != S_OVER && score_d > hi_q) hi_d = score_d;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) hi_q <= '0;
    else         hi_q <= hi_d;
  end

  assign bus.oHighScore = hi_q;
`else
  assign bus.oHighScore = '0;
`endif
endmodule

// File: tb/tb_collision_scorer.sv
// Randomized bench for collision_scorer against a frame-level game model,
// plus a narrow SCORE_W=8 instance for saturation.
module tb_collision_scorer;
  localparam int NB = 4;
  localparam int NR = 10;
  localparam int NO = 1 + NB + NR;
  localparam int SW = 16;
  localparam int LI = 3;
  localparam int IFR = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  collision_scorer_if #(.N_OBJ(NO), .SCORE_W(SW)) bus ();
  collision_scorer #(.N_BULLET(NB), .N_ROCK(NR), .SCORE_W(SW), .POINTS(10),
                     .LIVES_INIT(LI), .INVULN_FRAMES(IFR))
    dut (.iCLK(clk), .iRST_N(rst_n), .bus(bus));

  collision_scorer_if #(.N_OBJ(NO), .SCORE_W(8)) bus8 ();
  collision_scorer #(.N_BULLET(NB), .N_ROCK(NR), .SCORE_W(8), .POINTS(10),
                     .LIVES_INIT(LI), .INVULN_FRAMES(IFR))
    dut8 (.iCLK(clk), .iRST_N(rst_n), .bus(bus8));

  int nchk = 0;
  int nerr = 0;

  // game model
  int m_state, m_score, m_hi, m_lives, m_cnt, m_frame;
  logic [NB-1:0] m_bacc;
  logic [NR-1:0] m_racc;
  logic          m_sacc;
  logic [NO-1:0] m_reset;
  logic exp_pix, obs_pix;

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_lives = 0; m_cnt = 0; m_frame = 0;
    m_bacc = '0; m_racc = '0; m_sacc = 1'b0; m_reset = '0;
  endtask

  task automatic model_edge(input logic [NO-1:0] pix, input logic tick, input logic ng);
    int nb, nr, nrock;
    logic [NB-1:0] fb;
    logic [NR-1:0] fr;
    logic fs;
    nb = 0; nr = 0; nrock = 0; fb = '0; fr = '0;
    for (int i = 0; i < NB; i++) nb += int'(pix[1+i]);
    for (int j = 0; j < NR; j++) nr += int'(pix[NB+1+j]);
    if (nb > 0 && nr > 0) begin
      for (int i = 0; i < NB; i++) fb[i] = pix[1+i];
      for (int j = 0; j < NR; j++) fr[j] = pix[NB+1+j];
    end
    fs = pix[0] && (nr > 0);
    m_reset = '0;
    if (tick) begin
      m_frame = (m_frame + 1) % 256;
      if (ng) begin
        m_reset = '1; m_score = 0; m_lives = LI; m_state = 1;
      end else if (m_state == 1 || m_state == 2) begin
        for (int j = 0; j < NR; j++) nrock += int'(m_racc[j]);
        for (int i = 0; i < NB; i++) m_reset[1+i] = m_bacc[i];
        for (int j = 0; j < NR; j++) m_reset[NB+1+j] = m_racc[j];
        m_score = m_score + nrock * 10;
        if (m_score > 65535) m_score = 65535;
        if (m_state == 1 && m_sacc) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin
            m_state = 3;
`ifdef COLLISION_SCORER_HIGH_SCORE_EN
            if (m_score > m_hi) m_hi = m_score;
`endif
          end else begin
            m_reset[0] = 1'b1; m_state = 2; m_cnt = IFR;
          end
        end else if (m_state == 2) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_state = 1;
        end
      end
      m_bacc = fb; m_racc = fr; m_sacc = fs;
    end else begin
      m_bacc = m_bacc | fb; m_racc = m_racc | fr; m_sacc = m_sacc | fs;
    end
  endtask

  function automatic logic [52:0] exp_vec();
    return {m_state[1:0], m_lives[2:0], m_score[15:0], m_hi[15:0], (m_state == 3), m_reset};
  endfunction

  function automatic logic [52:0] obs_vec();
    return {bus.oState, bus.oLives, bus.oScore, bus.oHighScore, bus.oGameOver, bus.oReset};
  endfunction

  task automatic step(input logic [NO-1:0] pix, input logic tick, input logic ng);
    @(negedge clk);
    bus.iPixels = pix; bus.iFrameTick = tick; bus.iNewGame = ng;
    #1;
    obs_pix = bus.oPixel;
    exp_pix = (m_state == 2 && (m_frame & 8) != 0) ? |pix[NO-1:1] : |pix;
    @(posedge clk);
    model_edge(pix, tick, ng);
    #1;
  endtask

  function automatic logic [NO-1:0] bits2(input int a, input int b);
    logic [NO-1:0] v;
    v = '0; v[a] = 1'b1; v[b] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    logic [NO-1:0] p;
    p = NO'($urandom) | NO'(2);
    bus.iPixels = p; bus.iFrameTick = 1'b0; bus.iNewGame = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #23;
    nchk++;
    if (obs_vec() !== 53'd0) begin
      nerr++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    nchk++;
    if (bus.oPixel !== 1'b1) begin
      nerr++; $display("FAIL reset_pixel: got %b want 1", bus.oPixel);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_new_game();
    step('0, 1'b1, 1'b1);
    nchk++;
    if ({bus.oReset, bus.oState, bus.oLives, bus.oScore} !== {15'h7fff, 2'd1, 3'd3, 16'd0}) begin
      nerr++; $display("FAIL new_game: got rst=%h st=%0d lives=%0d score=%0d want rst=7fff st=1 lives=3 score=0",
                       bus.oReset, bus.oState, bus.oLives, bus.oScore);
    end
    step('0, 1'b0, 1'b0);
    nchk++;
    if (bus.oReset !== '0) begin
      nerr++; $display("FAIL new_game_pulse: got %h want 0", bus.oReset);
    end
  endtask

  task automatic test_two_rocks();
    step(bits2(1, 10), 1'b0, 1'b0);
    step(bits2(2, 12), 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    nchk++;
    if ({bus.oReset, bus.oScore} !== {15'h1406, 16'd20}) begin
      nerr++; $display("FAIL two_rocks: got rst=%h score=%0d want rst=1406 score=20", bus.oReset, bus.oScore);
    end
    nchk++;
    if (obs_vec() !== exp_vec()) begin
      nerr++; $display("FAIL two_rocks_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_tick_hit();
    step(bits2(3, 11), 1'b1, 1'b0);
    nchk++;
    if ({bus.oReset, bus.oScore} !== {15'h0000, 16'd20}) begin
      nerr++; $display("FAIL tick_hit_now: got rst=%h score=%0d want rst=0 score=20", bus.oReset, bus.oScore);
    end
    step('0, 1'b1, 1'b0);
    nchk++;
    if ({bus.oReset, bus.oScore} !== {15'h0808, 16'd30}) begin
      nerr++; $display("FAIL tick_hit_next: got rst=%h score=%0d want rst=0808 score=30", bus.oReset, bus.oScore);
    end
  endtask

  task automatic test_back_to_back();
    step(bits2(4, 13), 1'b0, 1'b0);
    step(bits2(1, 6), 1'b1, 1'b0);
    nchk++;
    if ({bus.oReset, bus.oScore} !== {15'h2010, 16'd40}) begin
      nerr++; $display("FAIL b2b_first: got rst=%h score=%0d want rst=2010 score=40", bus.oReset, bus.oScore);
    end
    step('0, 1'b1, 1'b0);
    nchk++;
    if ({bus.oReset, bus.oScore} !== {15'h0042, 16'd50}) begin
      nerr++; $display("FAIL b2b_second: got rst=%h score=%0d want rst=0042 score=50", bus.oReset, bus.oScore);
    end
    nchk++;
    if (obs_vec() !== exp_vec()) begin
      nerr++; $display("FAIL b2b_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_invuln();
    step('0, 1'b1, 1'b1);
    step(bits2(0, 9), 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    nchk++;
    if ({bus.oLives, bus.oState, bus.oReset} !== {3'd2, 2'd2, 15'h0001}) begin
      nerr++; $display("FAIL invuln_enter: got lives=%0d st=%0d rst=%h want lives=2 st=2 rst=0001",
                       bus.oLives, bus.oState, bus.oReset);
    end
    for (int k = 1; k <= IFR; k++) begin
      step(NO'(1), 1'b0, 1'b0);
      nchk++;
      if (obs_pix !== exp_pix) begin
        nerr++; $display("FAIL blink k=%0d: got %b want %b", k, obs_pix, exp_pix);
      end
      step(bits2(0, 7), 1'b1, 1'b0);
      nchk++;
      if (obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL invuln_tick k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
    nchk++;
    if ({bus.oState, bus.oLives} !== {2'd1, 3'd2}) begin
      nerr++; $display("FAIL invuln_expire: got st=%0d lives=%0d want st=1 lives=2", bus.oState, bus.oLives);
    end
  endtask

  task automatic test_game_over();
    logic [SW-1:0] want_hi;
    step('0, 1'b1, 1'b1);
    step(bits2(2, 8), 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    for (int h = 1; h <= 3; h++) begin
      step(bits2(0, 14), 1'b0, 1'b0);
      step('0, 1'b1, 1'b0);
      if (h < 3) for (int k = 0; k < IFR; k++) step('0, 1'b1, 1'b0);
    end
`ifdef COLLISION_SCORER_HIGH_SCORE_EN
    want_hi = 16'd10;
`else
    want_hi = 16'd0;
`endif
    nchk++;
    if ({bus.oLives, bus.oState, bus.oGameOver, bus.oScore, bus.oHighScore} !==
        {3'd0, 2'd3, 1'b1, 16'd10, want_hi}) begin
      nerr++; $display("FAIL game_over: got lives=%0d st=%0d go=%b score=%0d hi=%0d want 0 3 1 10 %0d",
                       bus.oLives, bus.oState, bus.oGameOver, bus.oScore, bus.oHighScore, want_hi);
    end
    nchk++;
    if (obs_vec() !== exp_vec()) begin
      nerr++; $display("FAIL game_over_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [NO-1:0] p;
    step('0, 1'b1, 1'b1);
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(2, 6);
      for (int c = 0; c < len; c++) begin
        p = NO'($urandom & $urandom & $urandom);
        step(p, 1'b0, 1'b0);
        nchk++;
        if (obs_pix !== exp_pix) begin
          nerr++; $display("FAIL rand_pixel f=%0d: got %b want %b", f, obs_pix, exp_pix);
        end
      end
      p = NO'($urandom & $urandom);
      step(p, 1'b1, ($urandom_range(0, 7) == 0));
      nchk++;
      if (obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL rand_commit f=%0d: got %h want %h", f, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic step8(input logic [NO-1:0] pix, input logic tick, input logic ng);
    @(negedge clk);
    bus8.iPixels = pix; bus8.iFrameTick = tick; bus8.iNewGame = ng;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int want;
    step8('0, 1'b1, 1'b1);
    want = 0;
    for (int f = 0; f < 4; f++) begin
      int nrk;
      nrk = (f < 2) ? 10 : (f == 2 ? 5 : 2);
      step8({NO'((1 << nrk) - 1) << (NB + 1)} | NO'(2), 1'b0, 1'b0);
      step8('0, 1'b1, 1'b0);
      want = want + nrk * 10;
      if (want > 255) want = 255;
      nchk++;
      if (int'(bus8.oScore) != want) begin
        nerr++; $display("FAIL saturation f=%0d: got %0d want %0d", f, bus8.oScore, want);
      end
    end
    step8({NO'(1) << (NB + 1)} | NO'(2), 1'b0, 1'b0);
    step8('0, 1'b1, 1'b0);
    nchk++;
    if (bus8.oScore !== 8'd255) begin
      nerr++; $display("FAIL saturation_hold: got %0d want 255", bus8.oScore);
    end
  endtask

  task automatic test_midframe_reset();
    step('0, 1'b1, 1'b1);
    step(bits2(1, 5) | NO'(1), 1'b0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (obs_vec() !== 53'd0) begin
      nerr++; $display("FAIL midframe_reset: got %h want 0", obs_vec());
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step('0, 1'b1, 1'b0);
    nchk++;
    if ({bus.oState, bus.oReset, bus.oScore, bus.oLives} !== {2'd0, 15'd0, 16'd0, 3'd0}) begin
      nerr++; $display("FAIL reset_then_commit: got st=%0d rst=%h score=%0d lives=%0d want all 0",
                       bus.oState, bus.oReset, bus.oScore, bus.oLives);
    end
  endtask

  initial begin
    bus.iPixels = '0; bus.iFrameTick = 1'b0; bus.iNewGame = 1'b0;
    bus8.iPixels = '0; bus8.iFrameTick = 1'b0; bus8.iNewGame = 1'b0;
    test_reset();
    test_new_game();
    test_two_rocks();
    test_tick_hit();
    test_back_to_back();
    test_invuln();
    test_game_over();
    test_random();
    test_saturation();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
